// File: rtl/laser500_scandoubler.sv
// laser500_scandoubler: 15 kHz to 31 kHz line doubler with a
// ping-pong line buffer and optional scanline darkening.
module laser500_scandoubler #(
  parameter int COLOR_W  = 6,
  parameter int MAX_LINE = 1024,
  parameter int HCNT_W   = 10
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [1:0]         scanlines,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic               hs_out,
  output logic               vs_out,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam logic [HCNT_W-1:0] H_MAX = HCNT_W'(MAX_LINE - 1);
  localparam logic [HCNT_W:0] LEN_RST = (HCNT_W+1)'(MAX_LINE);

  typedef enum logic {EMPTY, RUN} state_t;

  state_t state;
  state_t state_nxt;

  logic [PIX_W-1:0]  mem [2*MAX_LINE];
  logic [PIX_W-1:0]  rd;
  logic [HCNT_W-1:0] in_h;
  logic [HCNT_W-1:0] out_h;
  logic [HCNT_W-1:0] hs_lo_cnt;
  logic [HCNT_W-1:0] hs_w;
  logic [HCNT_W:0]   line_len;
  logic sat, wsel, copy, vs_lat, vs_hold, hs_prev;
  logic line_start, out_wrap, valid;
  logic hs_a, vs_a;
  logic hs_d, vs_d, copy_d, valid_d;

  assign line_start = ce_pix & hs_prev & ~hs_in;
  assign out_wrap   = {1'b0, out_h} == line_len - 1'b1;
  assign valid      = state == RUN;
  assign hs_a       = ~(out_h < hs_w);
  assign vs_a       = (out_h == '0) ? vs_lat : vs_hold;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (line_start) state_nxt = RUN;
      RUN:   state_nxt = RUN;
    endcase
  end

  // The strobe carrying the hs edge still belongs to the old line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      in_h      <= '0;
      sat       <= 1'b0;
      wsel      <= 1'b0;
      hs_prev   <= 1'b1;
      hs_lo_cnt <= '0;
      hs_w      <= '0;
      line_len  <= LEN_RST;
      vs_lat    <= 1'b1;
    end else if (ce_pix) begin
      hs_prev <= hs_in;
      if (line_start) begin
        line_len  <= {1'b0, in_h} + 1'b1;
        hs_w      <= hs_lo_cnt;
        hs_lo_cnt <= HCNT_W'(1);
        vs_lat    <= vs_in;
        wsel      <= ~wsel;
        in_h      <= '0;
        sat       <= 1'b0;
      end else begin
        if (!sat) begin
          if (in_h == H_MAX) sat <= 1'b1;
          else               in_h <= in_h + 1'b1;
        end
        if (!hs_in && hs_lo_cnt != '1)
          hs_lo_cnt <= hs_lo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ce_pix && !sat)
      mem[{wsel, in_h}] <= {r_in, g_in, b_in};
    rd <= mem[{~wsel, out_h}];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_h   <= '0;
      copy    <= 1'b0;
      vs_hold <= 1'b1;
    end else begin
      vs_hold <= vs_a;
      if (line_start) begin
        out_h <= '0;
        copy  <= 1'b0;
      end else if (out_wrap) begin
        out_h <= '0;
        copy  <= ~copy;
      end else begin
        out_h <= out_h + 1'b1;
      end
    end
  end

  function automatic logic [COLOR_W-1:0] atten(
    input logic [COLOR_W-1:0] x,
    input logic               dim,
    input logic [1:0]         sl
  );
    logic [COLOR_W-1:0] y;
    y = x;
    unique case (1'b1)
      (dim && sl == 2'b01): y = x - (x >> 2);
      (dim && sl == 2'b10): y = x >> 1;
      (dim && sl == 2'b11): y = x >> 2;
      default:              y = x;
    endcase
    return y;
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      copy_d  <= 1'b0;
      valid_d <= 1'b0;
      hs_out  <= 1'b1;
      vs_out  <= 1'b1;
      r_out   <= '0;
      g_out   <= '0;
      b_out   <= '0;
    end else begin
      hs_d    <= hs_a;
      vs_d    <= vs_a;
      copy_d  <= copy;
      valid_d <= valid;
      hs_out  <= hs_d;
      vs_out  <= vs_d;
      if (valid_d) begin
        r_out <= atten(rd[PIX_W-1 -: COLOR_W], copy_d, scanlines);
        g_out <= atten(rd[2*COLOR_W-1 -: COLOR_W], copy_d, scanlines);
        b_out <= atten(rd[COLOR_W-1:0], copy_d, scanlines);
      end else begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_laser500_scandoubler.sv
// tb_laser500_scandoubler: random and directed line stimulus
// compared against a line-level model of the doubled video.
module tb_laser500_scandoubler;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix = 1'b0;
  logic [1:0] scanlines = 2'd0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic [5:0] r_in = '0;
  logic [5:0] g_in = '0;
  logic [5:0] b_in = '0;
  logic       hs_out, vs_out;
  logic [5:0] r_out, g_out, b_out;

  int passed = 0;
  int total = 0;
  int cyc = 0;

  always #5 clk_sys = ~clk_sys;

  laser500_scandoubler dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .scanlines(scanlines), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  // One record per captured input line, effective 2 clocks after its edge.
  typedef struct {
    int cyc;
    int len;
    int hsw;
    bit vs;
    int slot;
  } rec_t;

  rec_t        recs[$];
  logic [17:0] pbuf [8][1024];
  logic [17:0] cur [1024];
  int          cur_n = 0;
  int          lo_cnt = 0;
  int          nslot = 0;
  bit          prev_hs = 1'b1;

  task automatic model_reset();
    recs.delete();
    cur_n = 0;
    lo_cnt = 0;
    prev_hs = 1'b1;
  endtask

  task automatic model_strobe(input bit hs, input bit vs,
                              input logic [17:0] px);
    rec_t r;
    if (cur_n < 1024) begin
      cur[cur_n] = px;
      cur_n++;
    end
    if (prev_hs && !hs) begin
      for (int i = 0; i < cur_n; i++) pbuf[nslot][i] = cur[i];
      r.cyc = cyc;
      r.len = cur_n;
      r.hsw = lo_cnt;
      r.vs = vs;
      r.slot = nslot;
      recs.push_back(r);
      if (recs.size() > 4) void'(recs.pop_front());
      nslot = (nslot + 1) % 8;
      cur_n = 0;
      lo_cnt = 1;
    end else if (!hs && lo_cnt < 1023) begin
      lo_cnt++;
    end
    prev_hs = hs;
  endtask

  function automatic logic [5:0] dim(input logic [5:0] x);
    int v;
    v = int'(x);
    case (scanlines)
      2'd1: v = v - v / 4;
      2'd2: v = v / 2;
      2'd3: v = v / 4;
      default: v = v;
    endcase
    return 6'(v);
  endfunction

  function automatic logic [19:0] expect_now();
    logic [19:0] e;
    logic [17:0] px;
    int j, k;
    bit found;
    e = {1'b1, 1'b1, 18'd0};
    found = 1'b0;
    for (int i = recs.size() - 1; i >= 0; i--) begin
      if (!found && recs[i].cyc + 2 <= cyc) begin
        found = 1'b1;
        j = cyc - recs[i].cyc - 2;
        k = j % recs[i].len;
        px = pbuf[recs[i].slot][k];
        if (((j / recs[i].len) % 2) == 1)
          px = {dim(px[17:12]), dim(px[11:6]), dim(px[5:0])};
        e = {(k >= recs[i].hsw), recs[i].vs, px};
      end
    end
    return e;
  endfunction

  function automatic logic [19:0] got();
    return {hs_out, vs_out, r_out, g_out, b_out};
  endfunction

  task automatic tick(input bit ce, input bit hs, input bit vs,
                      input logic [17:0] px);
    ce_pix = ce;
    hs_in = hs;
    vs_in = vs;
    {r_in, g_in, b_in} = px;
    @(posedge clk_sys);
    cyc++;
    if (ce) model_strobe(hs, vs, px);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if (hs_out !== 1'b1) $display("FAIL reset_hs got=%b want=1", hs_out);
    else passed++;
    total++;
    if (vs_out !== 1'b1) $display("FAIL reset_vs got=%b want=1", vs_out);
    else passed++;
    total++;
    if ({r_out, g_out, b_out} !== 18'd0)
      $display("FAIL reset_rgb got=%h want=0", {r_out, g_out, b_out});
    else passed++;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      tick(c % 2 == 0, 1'b1, 1'b1, 18'($urandom));
      e = expect_now();
      total++;
      if (got() !== e) $display("FAIL idle cyc=%0d got=%h want=%h", cyc, got(), e);
      else passed++;
    end
  endtask

  task automatic test_line_timing();
    logic [19:0] e;
    logic [17:0] px;
    int lows;
    lows = 0;
    for (int ln = 0; ln < 4; ln++)
      for (int s = 0; s < 952; s++)
        for (int p = 0; p < 2; p++) begin
          px = 18'(ln * 4099 + s * 3);
          if (p == 0) tick(1'b1, s >= 68, 1'b1, px);
          else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
          e = expect_now();
          total++;
          if (got() !== e)
            $display("FAIL timing cyc=%0d got=%h want=%h", cyc, got(), e);
          else passed++;
          if (ln == 3 && hs_out == 1'b0) lows++;
        end
    total++;
    if (lows !== 136) $display("FAIL hs_width got=%0d want=136", lows);
    else passed++;
  endtask

  task automatic test_scanlines();
    logic [19:0] e;
    int mn, mx, want;
    for (int sl = 1; sl < 4; sl++) begin
      scanlines = 2'(sl);
      want = (sl == 1) ? 30 : (sl == 2) ? 20 : 10;
      mn = 63;
      mx = 0;
      for (int ln = 0; ln < 4; ln++)
        for (int s = 0; s < 60; s++)
          for (int p = 0; p < 2; p++) begin
            if (p == 0) tick(1'b1, s >= 6, 1'b1, {6'd40, 6'd40, 6'd40});
            else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
            e = expect_now();
            total++;
            if (got() !== e)
              $display("FAIL scan cyc=%0d got=%h want=%h", cyc, got(), e);
            else passed++;
            if (ln == 3) begin
              for (int c = 0; c < 3; c++) begin
                if (int'(got() >> (6 * c)) % 64 < mn) mn = int'(got() >> (6 * c)) % 64;
                if (int'(got() >> (6 * c)) % 64 > mx) mx = int'(got() >> (6 * c)) % 64;
              end
            end
          end
      total++;
      if (mn !== want) $display("FAIL scan_dim sl=%0d got=%0d want=%0d", sl, mn, want);
      else passed++;
      total++;
      if (mx !== 40) $display("FAIL scan_full sl=%0d got=%0d want=40", sl, mx);
      else passed++;
    end
    scanlines = 2'd0;
  endtask

  task automatic test_vsync();
    logic [19:0] e;
    int lows;
    lows = 0;
    for (int ln = 0; ln < 7; ln++)
      for (int s = 0; s < 100; s++)
        for (int p = 0; p < 2; p++) begin
          if (p == 0)
            tick(1'b1, s >= 8, !(ln >= 1 && ln <= 3), 18'($urandom));
          else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
          e = expect_now();
          total++;
          if (got() !== e) $display("FAIL vsync cyc=%0d got=%h want=%h", cyc, got(), e);
          else passed++;
          if (vs_out == 1'b0) lows++;
        end
    total++;
    if (lows !== 600) $display("FAIL vs_lines got=%0d want=600", lows);
    else passed++;
  endtask

  task automatic test_long_line();
    logic [19:0] e;
    logic [17:0] px;
    int e1, lens[3];
    e1 = 0;
    lens = '{1100, 1100, 50};
    for (int ln = 0; ln < 3; ln++)
      for (int s = 0; s < lens[ln]; s++)
        for (int p = 0; p < 2; p++) begin
          if (ln == 0) px = (s == 0) ? 18'h3ffff : 18'(s - 1);
          else px = 18'($urandom);
          if (p == 0) tick(1'b1, s >= 40, 1'b1, px);
          else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
          if (ln == 1 && s == 0 && p == 0) e1 = cyc;
          e = expect_now();
          total++;
          if (got() !== e) $display("FAIL long cyc=%0d got=%h want=%h", cyc, got(), e);
          else passed++;
          if (ln == 1 && (cyc == e1 + 2 || cyc == e1 + 1026)) begin
            total++;
            if (got() !== {1'b0, 1'b1, 18'd0})
              $display("FAIL long_pix0 cyc=%0d got=%h want=%h", cyc, got(), {1'b0, 1'b1, 18'd0});
            else passed++;
          end
          if (ln == 1 && cyc == e1 + 1025) begin
            total++;
            if (got() !== {1'b1, 1'b1, 18'd1023})
              $display("FAIL long_pix1023 got=%h want=%h", got(), {1'b1, 1'b1, 18'd1023});
            else passed++;
          end
        end
  endtask

  task automatic test_ce_gap();
    logic [19:0] e;
    for (int ln = 0; ln < 3; ln++)
      for (int s = 0; s < 80; s++) begin
        if (ln == 1 && s == 30)
          for (int g = 0; g < 10; g++) begin
            tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
            e = expect_now();
            total++;
            if (got() !== e) $display("FAIL ce_gap cyc=%0d got=%h want=%h", cyc, got(), e);
            else passed++;
          end
        for (int p = 0; p < 2; p++) begin
          if (p == 0) tick(1'b1, s >= 8, 1'b1, 18'($urandom));
          else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
          e = expect_now();
          total++;
          if (got() !== e) $display("FAIL ce_line cyc=%0d got=%h want=%h", cyc, got(), e);
          else passed++;
        end
      end
  endtask

  task automatic test_reset_midline();
    logic [19:0] e;
    for (int s = 0; s < 90; s++)
      for (int p = 0; p < 2; p++) begin
        if (p == 0) tick(1'b1, s >= 6 && s != 60, 1'b1, 18'($urandom));
        else tick(1'b0, 1'b1, 1'b1, 18'($urandom));
      end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({hs_out, vs_out, r_out, g_out, b_out} !== {1'b1, 1'b1, 18'd0})
      $display("FAIL async_reset got=%h want=%h", got(), {1'b1, 1'b1, 18'd0});
    else passed++;
    reset_n = 1'b1;
    model_reset();
    for (int ln = 0; ln < 4; ln++)
      for (int s = 0; s < 60; s++)
        for (int p = 0; p < 2; p++) begin
          if (p == 0) tick(1'b1, ln == 0 || s >= 5, 1'b1, 18'($urandom));
          else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
          e = expect_now();
          total++;
          if (got() !== e) $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, got(), e);
          else passed++;
        end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    int len, w;
    for (int ln = 0; ln < 25; ln++) begin
      len = $urandom_range(8, 90);
      w = $urandom_range(1, len - 1);
      scanlines = 2'($urandom);
      for (int s = 0; s < len; s++)
        for (int p = 0; p < 2; p++) begin
          if (p == 0) tick(1'b1, s >= w, 1'($urandom), 18'($urandom));
          else tick(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
          e = expect_now();
          total++;
          if (got() !== e) $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, got(), e);
          else passed++;
        end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_scanlines();
    test_vsync();
    test_long_line();
    test_ce_gap();
    test_reset_midline();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
